gf2m_trinomial_reducer: RTL and testbench

- Sequential modular-reduction stage directly downstream of the 233-bit Karatsuba/OBS binary-field multiplier.
- Takes the raw 465-bit carry-less product and reduces it modulo the trinomial f(x) = x^M + x^K + 1 (default NIST B-233/K-233: x^233 + x^74 + 1).
- Produces a 233-bit field element.
- Uses valid/ready handshakes on both sides so it can sit between the combinational multiplier and the point-arithmetic controller.

---
 rtl/gf2m_trinomial_reducer.sv | 82 ++++++++
 tb/tb_gf2m_trinomial_reducer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_trinomial_reducer.sv
// gf2m_trinomial_reducer: reduces a 2M-1 bit carry-less product
// modulo x^M + x^K + 1 using two sequential folds.
module gf2m_trinomial_reducer #(
  parameter int M = 233,
  parameter int K = 74
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-2:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data
);

  localparam int W = 2*M-1;

  // Two folds only suffice when the middle term is small enough.
  if (K < 1 || K > (M-1)/2) begin : g_bad_k
    $error("gf2m_trinomial_reducer: K out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    FOLD1,
    FOLD2,
    DONE
  } state_t;

  state_t       state;
  logic [W-1:0] acc;
  logic [W-1:0] hi;
  logic [W-1:0] fold;

  // One fold: x^M == x^K + 1, so H*x^M -> H ^ (H << K).
  always_comb begin
    hi   = W'(acc[W-1:M]);
    fold = W'(acc[M-1:0]) ^ hi ^ (hi << K);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= in_data;
            state    <= FOLD1;
            in_ready <= 1'b0;
          end
        end
        FOLD1: begin
          acc   <= fold;
          state <= FOLD2;
        end
        FOLD2: begin
          acc       <= fold;
          state     <= DONE;
          out_valid <= 1'b1;
          out_data  <= fold[M-1:0];
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// tb_gf2m_trinomial_reducer: directed and random checks of the
// trinomial reducer against a long-division reference model.
module tb_gf2m_trinomial_reducer;

  localparam int M = 233;
  localparam int K = 74;
  localparam int W = 2*M-1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [M-1:0] exp_q[$];
  int           pop_cyc[$];

  gf2m_trinomial_reducer #(.M(M), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] xp(input int n);
    logic [W-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [M-1:0] ref_mod(input logic [W-1:0] c);
    logic [W-1:0] r;
    r = c;
    for (int i = W-1; i >= M; i--) begin
      if (r[i]) begin
        r[i]       = 1'b0;
        r[i-M+K]   = ~r[i-M+K];
        r[i-M]     = ~r[i-M];
      end
    end
    return r[M-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [479:0] t;
    for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] clmul(input logic [M-1:0] a,
                                         input logic [M-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) r = r ^ (W'(a) << i);
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        chk("done_hi_zero", W'(dut.acc[W-1:M]), '0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", W'(out_data), '1);
          end else begin
            chk("result", W'(out_data), W'(exp_q.pop_front()));
            pop_cyc.push_back(cyc);
          end
        end
      end else begin
        chk("idle_data_zero", W'(out_data), '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input logic [W-1:0] d,
                          input logic [M-1:0] e);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(e);
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("accept_timeout", W'(in_ready), W'(1'b1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    send_exp(d, ref_mod(d));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", W'(exp_q.size()), '0);
  endtask

  initial begin
    logic [M-1:0] e;
    logic [M-1:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_out_data", W'(out_data), '0);
    #3 rst = 1'b0;
    tick();

    // identity, latency, then backpressure with a pending input
    in_valid = 1'b1;
    in_data  = xp(0);
    exp_q.push_back(M'(1));
    tick();
    in_data = xp(232);
    e       = '0;
    e[232]  = 1'b1;
    exp_q.push_back(e);
    chk("lat1", W'(out_valid), '0);
    tick();
    chk("lat2", W'(out_valid), '0);
    tick();
    chk("lat3", W'(out_valid), W'(1'b1));
    chk("id_data", W'(out_data), W'(1'b1));
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", W'(out_valid), W'(1'b1));
      chk("bp_data", W'(out_data), W'(held));
      chk("bp_in_ready", W'(in_ready), '0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle", W'(in_ready), W'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("bp_accept", W'(in_ready), '0);
    drain();

    // single and double folds
    e     = '0;
    e[74] = 1'b1;
    e[0]  = 1'b1;
    send_exp(xp(233), e);
    e      = '0;
    e[231] = 1'b1;
    e[146] = 1'b1;
    e[72]  = 1'b1;
    send_exp(xp(464), e);
    send('1);
    drain();

    // asynchronous reset while folding
    out_ready = 1'b0;
    send(xp(233));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", W'(out_valid), '0);
    chk("mid_rst_ready", W'(in_ready), W'(1'b1));
    chk("mid_rst_data", W'(out_data), '0);
    exp_q.delete();
    #3 rst = 1'b0;
    tick();
    out_ready = 1'b1;
    e     = '0;
    e[74] = 1'b1;
    e[0]  = 1'b1;
    send_exp(xp(233), e);
    tick();
    tick();
    chk("post_rst_lat", W'(out_valid), W'(1'b1));
    drain();

    // back-to-back with in_valid held
    pop_cyc.delete();
    send(rnd_w());
    send(rnd_w());
    drain();
    chk("b2b_count", W'(pop_cyc.size()), W'(2));
    if (pop_cyc.size() == 2)
      chk("b2b_spacing", W'(pop_cyc[1] - pop_cyc[0]), W'(4));

    // random products and multiplier outputs
    for (int i = 0; i < 500; i++) send(rnd_w());
    for (int i = 0; i < 500; i++)
      send(clmul(M'(rnd_w()), M'(rnd_w())));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
